multicycle_control_fsm: RTL and testbench

Moore/Mealy control sequencer that drives the multi-cycle variant of the RISC-V datapath (shared ALU, IR/MDR/ALUOut registers) one instruction at a time. It replaces the single-cycle Control_Unit, adds a ready/valid wait on data memory with a timeout, supports halt requests, and flags illegal opcodes. It also counts retired instructions.

---
 rtl/multicycle_control_fsm.sv | 135 +++++++++++++
 tb/tb_multicycle_control_fsm.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequences the multi-cycle RISC-V datapath with memory wait/timeout, halt, illegal-opcode trap and retire count
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSource,
  output logic [3:0]       state,
  output logic             busy,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
    ADDR = 4'd4, MEM_RD = 4'd5, MEM_WR = 4'd6, WB_ALU = 4'd7,
    WB_MEM = 4'd8, BRANCH = 4'd9, HALT = 4'd10, TRAP = 4'd11
  } state_t;
  state_t     cur, nxt;
  logic [7:0] wcnt;
  logic       mem_st, wait_out, retire;
  assign state    = cur;
  assign busy     = !(cur == HALT || cur == TRAP);
  assign mem_st   = cur == MEM_RD || cur == MEM_WR;
  assign wait_out = wcnt == 8'(MEM_TIMEOUT) && !mem_ready;
  assign retire   = cur == WB_ALU || cur == WB_MEM || cur == BRANCH || (cur == MEM_WR && mem_ready);
  // next-state and control outputs; enables are forced low while reset is held
  always_comb begin
    nxt      = cur;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 1'b0;
    case (cur)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = !halt_req;
        PCWrite = !halt_req;
        nxt     = halt_req ? HALT : DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        nxt = opcode == 7'b0110011 ? EXEC_R :
              opcode == 7'b0010011 ? EXEC_I :
              (opcode == 7'b0000011 || opcode == 7'b0100011) ? ADDR :
              opcode == 7'b1100011 ? BRANCH : TRAP;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nxt     = WB_ALU;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        nxt     = WB_ALU;
      end
      ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = opcode == 7'b0100011 ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        nxt     = mem_ready ? WB_MEM : wait_out ? TRAP : MEM_RD;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        nxt      = mem_ready ? FETCH : wait_out ? TRAP : MEM_WR;
      end
      WB_ALU: begin
        RegWrite = 1'b1;
        nxt      = FETCH;
      end
      WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        nxt      = FETCH;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 1'b1;
        PCWrite  = zero;
        nxt      = FETCH;
      end
      HALT:    nxt = halt_req ? HALT : FETCH;
      default: nxt = TRAP;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end
  // state, memory wait counter, sticky flags and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= FETCH;
      wcnt    <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
      retired <= '0;
    end else begin
      cur     <= nxt;
      wcnt    <= cur == ADDR ? 8'd0 : (mem_st && !mem_ready) ? wcnt + 8'd1 : wcnt;
      illegal <= illegal | (cur == DECODE && nxt == TRAP);
      timeout <= timeout | (mem_st && wait_out);
      retired <= retired + CNT_W'(retire);
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: scoreboard bench for the multi-cycle control sequencer
module tb_multicycle_control_fsm;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;
  localparam logic [11:0] C_FETCH = 12'hC08, C_FHALT = 12'h008, C_DEC = 12'h018;
  localparam logic [11:0] C_EXR = 12'h024, C_EXI = 12'h034, C_ADDR = 12'h030;
  localparam logic [11:0] C_MRD = 12'h200, C_MWR = 12'h100, C_WBA = 12'h080;
  localparam logic [11:0] C_WBM = 12'h0C0, C_BRT = 12'h823, C_BRN = 12'h023, C_IDLE = 12'h000;
  logic clk = 1'b0, reset = 1'b0;
  logic [6:0] opcode = '0;
  logic zero = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
  logic PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, ALUSrcA, PCSource;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] state;
  logic busy, illegal, timeout;
  logic [31:0] retired;
  logic [11:0] ctl_w;
  typedef struct {
    logic [3:0]  st;
    logic [11:0] ctl;
    logic        bsy;
    logic        ill;
    logic        tmo;
    logic [31:0] ret;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  logic [31:0] er = '0;
  logic ei = 1'b0, et = 1'b0;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .halt_req(halt_req), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .busy(busy),
    .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  always #5 clk = ~clk;
  assign ctl_w = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("ctl", 32'(ctl_w), 32'(e.ctl));
      chk("busy", 32'(busy), 32'(e.bsy));
      chk("illegal", 32'(illegal), 32'(e.ill));
      chk("timeout", 32'(timeout), 32'(e.tmo));
      chk("retired", retired, e.ret);
    end
  end

  task automatic cy(input logic [3:0] st, input logic [11:0] ctl, input logic rt);
    sb.push_back('{st, ctl, !(st == 4'd10 || st == 4'd11), ei, et, er});
    @(posedge clk);
    #1;
    er = er + 32'(rt);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctl", 32'(ctl_w), 32'(C_FHALT));
    chk("rst_flags", {29'd0, illegal, timeout, busy}, 32'd1);
    chk("rst_retired", retired, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    er = '0; ei = 1'b0; et = 1'b0;
    zero = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    do_reset();
    opcode = OP_R;
    cy(4'd0, C_FETCH, 0); cy(4'd1, C_DEC, 0); cy(4'd2, C_EXR, 0); cy(4'd7, C_WBA, 1);
    opcode = OP_I;
    cy(4'd0, C_FETCH, 0); cy(4'd1, C_DEC, 0); cy(4'd3, C_EXI, 0); cy(4'd7, C_WBA, 1);
    cy(4'd0, C_FETCH, 0);

    do_reset();
    opcode = OP_LD;
    cy(4'd0, C_FETCH, 0); cy(4'd1, C_DEC, 0); cy(4'd4, C_ADDR, 0);
    for (int i = 0; i < 3; i++) cy(4'd5, C_MRD, 0);
    mem_ready = 1'b1; cy(4'd5, C_MRD, 0);
    mem_ready = 1'b0; cy(4'd8, C_WBM, 1); cy(4'd0, C_FETCH, 0);

    do_reset();
    opcode = OP_ST;
    cy(4'd0, C_FETCH, 0); cy(4'd1, C_DEC, 0); cy(4'd4, C_ADDR, 0);
    for (int i = 0; i < 16; i++) cy(4'd6, C_MWR, 0);
    et = 1'b1;
    for (int i = 0; i < 3; i++) cy(4'd11, C_IDLE, 0);

    do_reset();
    opcode = OP_ST;
    cy(4'd0, C_FETCH, 0); cy(4'd1, C_DEC, 0); cy(4'd4, C_ADDR, 0);
    for (int i = 0; i < 15; i++) cy(4'd6, C_MWR, 0);
    mem_ready = 1'b1; cy(4'd6, C_MWR, 1);
    mem_ready = 1'b0; cy(4'd0, C_FETCH, 0);

    do_reset();
    opcode = OP_BR; zero = 1'b1;
    cy(4'd0, C_FETCH, 0); cy(4'd1, C_DEC, 0); cy(4'd9, C_BRT, 1);
    zero = 1'b0;
    cy(4'd0, C_FETCH, 0); cy(4'd1, C_DEC, 0); cy(4'd9, C_BRN, 1);
    cy(4'd0, C_FETCH, 0);

    do_reset();
    opcode = OP_BAD;
    cy(4'd0, C_FETCH, 0); cy(4'd1, C_DEC, 0);
    ei = 1'b1;
    cy(4'd11, C_IDLE, 0); cy(4'd11, C_IDLE, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    er = '0; ei = 1'b0;

    opcode = OP_R;
    cy(4'd0, C_FETCH, 0);
    halt_req = 1'b1;
    cy(4'd1, C_DEC, 0); cy(4'd2, C_EXR, 0); cy(4'd7, C_WBA, 1);
    cy(4'd0, C_FHALT, 0); cy(4'd10, C_IDLE, 0);
    halt_req = 1'b0;
    cy(4'd10, C_IDLE, 0);
    opcode = OP_LD;
    cy(4'd0, C_FETCH, 0); cy(4'd1, C_DEC, 0); cy(4'd4, C_ADDR, 0); cy(4'd5, C_MRD, 0);
    chk("memrd_before", 32'(MemRead), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("memrd_async", 32'(MemRead), 32'd0);
    chk("memrd_state", 32'(state), 32'd0);
    chk("memrd_retired", retired, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
